// File: rtl/poly_horner_eval_if.sv
// Operand-entry / result bus of the Horner polynomial evaluator.
// master = operand-entry side, slave = evaluator.
interface poly_horner_eval_if #(
  parameter int WIDTH  = 16,
  parameter int XWIDTH = 8,
  parameter int DEGREE = 2,
  parameter int AW     = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1
) ();
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [WIDTH-1:0]  coef_data;
  logic              start;
  logic [XWIDTH-1:0] X;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  resultado;
  logic              overflow;

  modport master (
    output coef_we, coef_addr, coef_data, start, X,
    input  busy, done, resultado, overflow
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, start, X,
    output busy, done, resultado, overflow
  );
endinterface

// File: rtl/poly_horner_eval.sv
// Horner-rule polynomial evaluator: coefficient file, one shared mul/add ALU,
// and a start/done FSM with sticky overflow detection.
//
// state | meaning
// IDLE  | waiting for start; coefficient writes accepted
// MUL   | S <= S*X (truncated), product overflow folded into sticky flag
// ADD   | S <= S + c[idx], carry folded into sticky flag; completes at idx=0
module poly_horner_eval #(
  parameter int WIDTH  = 16,
  parameter int XWIDTH = 8,
  parameter int DEGREE = 2,
  parameter int AW     = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1
) (
  input logic                 clk,
  input logic                 rst_n,
  poly_horner_eval_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_e;

  localparam int unsigned    TOP      = DEGREE;
  localparam logic [AW-1:0]  IDX_INIT = (DEGREE > 0) ? AW'(DEGREE - 1) : '0;

  state_e             state_q;
  logic [WIDTH-1:0]   coef_q [DEGREE+1];
  logic [WIDTH-1:0]   s_q;
  logic [WIDTH-1:0]   x_q;
  logic [AW-1:0]      idx_q;
  logic               ovf_s_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   res_q;
  logic               ovf_q;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;
  logic               coef_wr_ok;

  assign prod = {{WIDTH{1'b0}}, s_q} * {{WIDTH{1'b0}}, x_q};
  assign sum  = {1'b0, s_q} + {1'b0, coef_q[idx_q]};

  assign coef_wr_ok = (state_q == IDLE) && bus.coef_we &&
                      ({{(32-AW){1'b0}}, bus.coef_addr} <= 32'(DEGREE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
      s_q     <= '0;
      x_q     <= '0;
      idx_q   <= '0;
      ovf_s_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Start reads the coefficient file before a same-edge write lands.
      if (coef_wr_ok) coef_q[bus.coef_addr] <= bus.coef_data;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q     <= WIDTH'(bus.X);
            s_q     <= coef_q[TOP];
            idx_q   <= IDX_INIT;
            ovf_s_q <= 1'b0;
            if (DEGREE == 0) begin
              res_q  <= coef_q[TOP];
              ovf_q  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state_q <= MUL;
              busy_q  <= 1'b1;
            end
          end
        end
        MUL: begin
          s_q     <= prod[WIDTH-1:0];
          ovf_s_q <= ovf_s_q | (|prod[2*WIDTH-1:WIDTH]);
          state_q <= ADD;
        end
        ADD: begin
          s_q     <= sum[WIDTH-1:0];
          ovf_s_q <= ovf_s_q | sum[WIDTH];
          if (idx_q == '0) begin
            res_q   <= sum[WIDTH-1:0];
            ovf_q   <= ovf_s_q | sum[WIDTH];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q - 1'b1;
            state_q <= MUL;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.resultado = res_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Scoreboard bench for poly_horner_eval (DEGREE=2, WIDTH=16, XWIDTH=8).
module tb_poly_horner_eval;
  localparam int WIDTH  = 16;
  localparam int XWIDTH = 8;
  localparam int DEGREE = 2;
  localparam int AW     = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [WIDTH:0] exp_q [$];

  poly_horner_eval_if #(.WIDTH(WIDTH), .XWIDTH(XWIDTH), .DEGREE(DEGREE), .AW(AW)) bus ();

  poly_horner_eval #(.WIDTH(WIDTH), .XWIDTH(XWIDTH), .DEGREE(DEGREE), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got res=0x%0h ovf=%0d expected no done",
                 bus.resultado, bus.overflow);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        if ({bus.overflow, bus.resultado} !== e) begin
          bad++;
          $display("FAIL result: got res=0x%0h ovf=%0d expected res=0x%0h ovf=%0d",
                   bus.resultado, bus.overflow, e[WIDTH-1:0], e[WIDTH]);
        end
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic set_coefs(input logic [WIDTH-1:0] c2, input logic [WIDTH-1:0] c1,
                           input logic [WIDTH-1:0] c0);
    wr(2'd2, c2); wr(2'd1, c1); wr(2'd0, c0);
  endtask

  // Drives start for one edge (t); returns at t+#1.
  task automatic issue(input logic [XWIDTH-1:0] xv, input logic [WIDTH-1:0] er,
                       input logic eo, input bit expect_done);
    @(negedge clk);
    bus.X = xv; bus.start = 1'b1;
    if (expect_done) exp_q.push_back({eo, er});
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called at t+#1; waits for done and checks it arrives exactly 4 edges later.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd4);
    chk({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run(input string name, input logic [XWIDTH-1:0] xv,
                     input logic [WIDTH-1:0] er, input logic eo);
    issue(xv, er, eo, 1'b1);
    wait_done(name);
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.start = 1'b0; bus.X = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res", 32'(bus.resultado), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);

    // Basic evaluation with protection attempt and back-to-back restart.
    set_coefs(16'd3, 16'd5, 16'd7);
    issue(8'd4, 16'd75, 1'b0, 1'b1);               // edge t
    chk("basic_busy_t", 32'(bus.busy), 32'd1);
    chk("basic_done_t", 32'(bus.done), 32'd0);
    @(posedge clk); #1;                            // t+1
    bus.start = 1'b1; bus.X = 8'd7;
    bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = 16'd100;
    @(posedge clk); #1;                            // t+2
    bus.start = 1'b0; bus.coef_we = 1'b0;
    @(posedge clk); #1;                            // t+3
    chk("basic_busy_t3", 32'(bus.busy), 32'd1);
    chk("basic_done_t3", 32'(bus.done), 32'd0);
    @(posedge clk); #1;                            // t+4
    chk("basic_done_t4", 32'(bus.done), 32'd1);
    chk("basic_busy_t4", 32'(bus.busy), 32'd0);
    bus.X = 8'd0; bus.start = 1'b1;                // restart inside the done cycle
    exp_q.push_back({1'b0, 16'd7});
    @(posedge clk); #1;                            // t+5
    bus.start = 1'b0;
    chk("b2b_done_cleared", 32'(bus.done), 32'd0);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b");
    @(posedge clk); #1;
    chk("b2b_done_pulse", 32'(bus.done), 32'd0);
    chk("b2b_res_held", 32'(bus.resultado), 32'd7);

    // Out-of-range write must not disturb the file.
    wr(2'd3, 16'hAAAA);
    run("oob_write", 8'd4, 16'd75, 1'b0);

    // Multiply overflow, then sticky flag cleared on the next run.
    set_coefs(16'h0100, 16'h0000, 16'h0000);
    run("mul_ovf", 8'h10, 16'h0000, 1'b1);
    wr(2'd2, 16'd1);
    run("ovf_clear", 8'd2, 16'd4, 1'b0);

    // Carry out of the final ADD.
    set_coefs(16'd0, 16'd1, 16'hFFFF);
    run("add_carry", 8'd1, 16'h0000, 1'b1);

    // Same-edge write and start: evaluation sees old c2=2, next run sees 5.
    set_coefs(16'd2, 16'd0, 16'd0);
    @(negedge clk);
    bus.coef_we = 1'b1; bus.coef_addr = 2'd2; bus.coef_data = 16'd5;
    bus.X = 8'd3; bus.start = 1'b1;
    exp_q.push_back({1'b0, 16'd18});
    @(posedge clk); #1;
    bus.start = 1'b0; bus.coef_we = 1'b0;
    wait_done("wr_start_old");
    @(posedge clk); #1;
    run("wr_start_new", 8'd3, 16'd45, 1'b0);

    // Leave a nonzero result with overflow set, then abort a run with reset.
    set_coefs(16'h0100, 16'h0000, 16'h0005);
    run("ovf_res5", 8'h10, 16'h0005, 1'b1);
    issue(8'h10, 16'h0, 1'b0, 1'b0);               // edge t
    @(posedge clk); #1;                            // after MUL edge
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_res", 32'(bus.resultado), 32'd0);
    chk("abort_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);                     // any stray done would be flagged
    #1;
    run("post_reset", 8'd9, 16'd0, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
